// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, enable levels, reset values.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_STALL_LU = 2'd2;
  localparam logic [1:0] ST_FREEZE   = 2'd3;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    S_RUN      = ST_RUN,
    S_FLUSH    = ST_FLUSH,
    S_STALL_LU = ST_STALL_LU,
    S_FREEZE   = ST_FREEZE
  } state_e;

  localparam state_e RESET_STATE = S_RUN;

endpackage

// File: rtl/wb_delay_line.sv
// Fixed-depth shift register with hold (freeze) and asynchronous clear.
module wb_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             hold,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] line;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      line <= '0;
    end else if (!hold) begin
      line[0] <= din;
      for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  assign dout = line[DEPTH-1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: jump flush, load-use stall/bubble, memory-busy freeze, delayed WB enable.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int REG_W     = 5,
  parameter int FLUSH_CYC = 1,
  parameter int WB_DELAY  = 1
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              ex2cu_jump_en_i,
  input  logic [ADDR_W-1:0] ex2cu_jump_addr_i,
  input  logic              ex2cu_mem_rd_i,
  input  logic [REG_W-1:0]  ex2cu_rd_i,
  input  logic [REG_W-1:0]  id2cu_rs1_i,
  input  logic [REG_W-1:0]  id2cu_rs2_i,
  input  logic [1:0]        id2cu_rs_vld_i,
  input  logic              id2cu_wb_en_i,
  input  logic              mem2cu_busy_i,
  output logic              cu2pc_jump_en_o,
  output logic [ADDR_W-1:0] cu2pc_jump_addr_o,
  output logic              cu2_refresh_flag_o,
  output logic              cu2_stall_o,
  output logic              cu2idex_bubble_o,
  output logic              cu2ex_wb_en_o
);

  localparam int              CNT_W      = $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);

  state_e           state, saved, cur;
  logic [CNT_W-1:0] cnt;
  logic             busy, jump, rs_hit, lu, refresh, wb_in;

  // While frozen, behaviour is that of the state we were in when busy rose.
  assign cur    = (state == S_FREEZE) ? saved : state;
  assign busy   = mem2cu_busy_i;
  assign jump   = ex2cu_jump_en_i & ~busy;
  assign rs_hit = (id2cu_rs_vld_i[0] && (id2cu_rs1_i == ex2cu_rd_i)) ||
                  (id2cu_rs_vld_i[1] && (id2cu_rs2_i == ex2cu_rd_i));
  assign lu     = ~busy & ~ex2cu_jump_en_i & (cur == S_RUN) & ex2cu_mem_rd_i &
                  (ex2cu_rd_i != '0) & rs_hit;
  assign refresh = jump | (~busy & (cur == S_FLUSH));

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state <= RESET_STATE;
      saved <= RESET_STATE;
      cnt   <= '0;
    end else if (busy) begin
      state <= S_FREEZE;
      saved <= cur;
    end else if (ex2cu_jump_en_i) begin
      if (FLUSH_CYC > 1) begin
        state <= S_FLUSH;
        cnt   <= FLUSH_LOAD;
      end else begin
        state <= S_RUN;
        cnt   <= '0;
      end
    end else begin
      case (cur)
        S_FLUSH: begin
          state <= (cnt == CNT_W'(1)) ? S_RUN : S_FLUSH;
          cnt   <= cnt - 1'b1;
        end
        S_RUN:   state <= lu ? S_STALL_LU : S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  // Flushed or bubbled instructions must never reach write-back.
  assign wb_in = id2cu_wb_en_i & ~refresh & ~lu;

  wb_delay_line #(.WIDTH(1), .DEPTH(WB_DELAY)) u_wb_line (
    .clk   (clk),
    .clear (rest),
    .hold  (busy),
    .din   (wb_in),
    .dout  (cu2ex_wb_en_o)
  );

  // Combinational outputs are forced low while reset is held.
  assign cu2pc_jump_en_o    = jump & ~rest;
  assign cu2pc_jump_addr_o  = (jump & ~rest) ? ex2cu_jump_addr_i : '0;
  assign cu2_refresh_flag_o = refresh & ~rest;
  assign cu2_stall_o        = (busy | lu) & ~rest;
  assign cu2idex_bubble_o   = lu & ~rest;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed literal checks plus randomized run against a counter-based model.
module tb_pipe_hazard_ctrl;

  localparam int AW = 32, RW = 5, FC = 2, WD = 3;

  logic          clk = 1'b0, rest = 1'b1;
  logic          jump_en = 1'b0, mem_rd = 1'b0, wb_en = 1'b0, busy = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic [RW-1:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [1:0]    rs_vld = '0;

  logic          o_jump, o_refresh, o_stall, o_bubble, o_wb;
  logic [AW-1:0] o_addr;

  int tests = 0, fails = 0;

  pipe_hazard_ctrl #(.ADDR_W(AW), .REG_W(RW), .FLUSH_CYC(FC), .WB_DELAY(WD)) dut (
    .clk                (clk),
    .rest               (rest),
    .ex2cu_jump_en_i    (jump_en),
    .ex2cu_jump_addr_i  (jump_addr),
    .ex2cu_mem_rd_i     (mem_rd),
    .ex2cu_rd_i         (rd),
    .id2cu_rs1_i        (rs1),
    .id2cu_rs2_i        (rs2),
    .id2cu_rs_vld_i     (rs_vld),
    .id2cu_wb_en_i      (wb_en),
    .mem2cu_busy_i      (busy),
    .cu2pc_jump_en_o    (o_jump),
    .cu2pc_jump_addr_o  (o_addr),
    .cu2_refresh_flag_o (o_refresh),
    .cu2_stall_o        (o_stall),
    .cu2idex_bubble_o   (o_bubble),
    .cu2ex_wb_en_o      (o_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    jump_en = 0; mem_rd = 0; wb_en = 0; busy = 0;
    jump_addr = '0; rd = '0; rs1 = '0; rs2 = '0; rs_vld = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      clr_in();
    end
  endtask

  // Model: remaining flush cycles, "just stalled" flag, and WB pipeline as a plain bit array.
  int frem = 0;
  bit alu = 0;
  bit wbq[WD];

  always @(negedge clk) begin : cmp
    bit ej, erf, est, ebub, ewb, hit;
    logic [AW-1:0] ea;
    ej = 0; erf = 0; est = 0; ebub = 0; ea = '0;
    ewb = wbq[WD-1];
    if (rest) begin
      ewb = 0; frem = 0; alu = 0;
      foreach (wbq[i]) wbq[i] = 0;
    end else if (busy) begin
      est = 1;
    end else begin
      ej   = jump_en;
      ea   = jump_en ? jump_addr : '0;
      erf  = jump_en || (frem > 0);
      hit  = (rs_vld[0] && rs1 == rd) || (rs_vld[1] && rs2 == rd);
      ebub = !jump_en && frem == 0 && !alu && mem_rd && (rd != 0) && hit;
      est  = ebub;
      for (int i = WD - 1; i > 0; i--) wbq[i] = wbq[i-1];
      wbq[0] = wb_en && !erf && !ebub;
      if (jump_en) frem = FC - 1;
      else if (frem > 0) frem--;
      alu = ebub;
    end
    chk("m_jump",    32'(o_jump),    32'(ej));
    chk("m_addr",    o_addr,         ea);
    chk("m_refresh", 32'(o_refresh), 32'(erf));
    chk("m_stall",   32'(o_stall),   32'(est));
    chk("m_bubble",  32'(o_bubble),  32'(ebub));
    chk("m_wb",      32'(o_wb),      32'(ewb));
  end

  initial begin
    // reset holds all outputs low even with active inputs
    jump_en = 1; jump_addr = 32'h1234; wb_en = 1;
    #3;
    chk("rst_jump", 32'(o_jump), 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_refresh", 32'(o_refresh), 0);
    chk("rst_wb", 32'(o_wb), 0);
    cyc(); rest = 0; clr_in();
    idle(2);

    // jump: refresh for FC cycles
    cyc(); jump_en = 1; jump_addr = 32'h80; #3;
    chk("t1_jump", 32'(o_jump), 1);
    chk("t1_addr", o_addr, 32'h80);
    chk("t1_ref0", 32'(o_refresh), 1);
    cyc(); clr_in(); #3;
    chk("t1_ref1", 32'(o_refresh), 1);
    chk("t1_jump1", 32'(o_jump), 0);
    cyc(); #3;
    chk("t1_ref2", 32'(o_refresh), 0);

    // load-use on rs1, one cycle only; rd=0 ignored; rs2 match
    cyc(); mem_rd = 1; rd = 5; rs1 = 5; rs_vld = 2'b01; #3;
    chk("t2_stall", 32'(o_stall), 1);
    chk("t2_bubble", 32'(o_bubble), 1);
    cyc(); #3;
    chk("t2_stall_once", 32'(o_stall), 0);
    cyc(); rd = 0; rs1 = 0; #3;
    chk("t2_rd0", 32'(o_stall), 0);
    cyc(); rd = 7; rs2 = 7; rs_vld = 2'b10; #3;
    chk("t2_rs2", 32'(o_bubble), 1);
    idle(2);

    // jump beats load-use
    cyc(); mem_rd = 1; rd = 5; rs1 = 5; rs_vld = 2'b01; jump_en = 1; jump_addr = 32'h40; #3;
    chk("t3_ref", 32'(o_refresh), 1);
    chk("t3_stall", 32'(o_stall), 0);
    chk("t3_bubble", 32'(o_bubble), 0);
    idle(3);

    // WB delay of WD cycles; killed when flushed
    cyc(); wb_en = 1; #3;
    chk("t4_wb0", 32'(o_wb), 0);
    cyc(); wb_en = 0; #3;
    chk("t4_wb1", 32'(o_wb), 0);
    cyc(); #3;
    chk("t4_wb2", 32'(o_wb), 0);
    cyc(); #3;
    chk("t4_wb3", 32'(o_wb), 1);
    cyc(); wb_en = 1; jump_en = 1; jump_addr = 32'h100; #3;
    for (int i = 0; i < 4; i++) begin
      cyc(); clr_in(); #3;
      chk("t4_wb_flushed", 32'(o_wb), 0);
    end

    // freeze during flush
    idle(2);
    cyc(); wb_en = 1;
    cyc(); wb_en = 0; jump_en = 1; jump_addr = 32'h44; #3;
    chk("t5_ref", 32'(o_refresh), 1);
    cyc(); jump_en = 0; busy = 1; #3;
    chk("t5_stall", 32'(o_stall), 1);
    chk("t5_noref", 32'(o_refresh), 0);
    cyc(); jump_en = 1; #3;
    chk("t5_nojump", 32'(o_jump), 0);
    chk("t5_wb_held", 32'(o_wb), 0);
    cyc(); jump_en = 0; #3;
    chk("t5_stall2", 32'(o_stall), 1);
    cyc(); busy = 0; #3;
    chk("t5_resume", 32'(o_refresh), 1);
    chk("t5_unstall", 32'(o_stall), 0);
    cyc(); #3;
    chk("t5_done", 32'(o_refresh), 0);
    chk("t5_wb_out", 32'(o_wb), 1);

    // async reset mid-flush
    idle(2);
    cyc(); jump_en = 1; jump_addr = 32'h88;
    cyc(); clr_in(); #1; rest = 1; #1;
    chk("t6_ref", 32'(o_refresh), 0);
    chk("t6_stall", 32'(o_stall), 0);
    cyc(); rest = 0; #3;
    chk("t6_run", 32'(o_refresh), 0);

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rest      = ($urandom_range(0, 199) == 0);
      jump_en   = ($urandom_range(0, 7) == 0);
      jump_addr = $urandom;
      busy      = ($urandom_range(0, 5) == 0);
      mem_rd    = $urandom_range(0, 1);
      rd        = RW'($urandom_range(0, 3));
      rs1       = RW'($urandom_range(0, 3));
      rs2       = RW'($urandom_range(0, 3));
      rs_vld    = 2'($urandom_range(0, 3));
      wb_en     = $urandom_range(0, 1);
    end
    cyc(); rest = 0; clr_in();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
